btn_press_decoder: RTL
======================

# btn_press_decoder

Consumes the debounced, active-low button level from the debouncer and classifies each user gesture into one of three events: single click, double click or long press. Sits between the debouncer and the application control logic. Each event is reported as a single-cycle pulse, so the downstream logic needs no edge detection or timers of its own.

## Interface

Parameters:
- LONG_CYC, 50_000_000: consecutive low samples that make a long press (1 s at 50 MHz); must be ≥ 2.
- GAP_CYC, 15_000_000: consecutive high samples after a short press that close the double-click window; must be ≥ 2.
- CW, 26: counter width; must satisfy 2^CW > max(LONG_CYC, GAP_CYC).

Ports:
- clk  input  1  system clock; single clock domain.
- rst_n  input  1  reset, asynchronous, active-low.
- btn_n  input  1  debounced button level, 0 = pressed; already synchronous to clk.
- single_click  output  1  one-cycle high pulse for a short press with no second press in the window.
- double_click  output  1  one-cycle high pulse when a second press starts inside the window.
- long_press  output  1  one-cycle high pulse when a press reaches LONG_CYC samples.
- held  output  1  high while the button is still held after a long_press.
- busy  output  1  high whenever the FSM is not in IDLE.

## Operation

- All outputs are registered. Reset value of every output is 0. The FSM resets to IDLE with cnt = 0.
- The FSM samples btn_n on every rising clk edge. cnt is CW bits wide and is only compared against LONG_CYC-1 and GAP_CYC-1, so it never wraps.
- IDLE:
  - btn_n=0 → PRESS1, cnt=1.
- PRESS1:
  - btn_n=0 and cnt==LONG_CYC-1 → HOLD, long_press pulse.
  - btn_n=0 otherwise → cnt++.
  - btn_n=1 → WAIT_GAP, cnt=1.
- WAIT_GAP:
  - btn_n=0 → WAIT_REL, double_click pulse. The low level takes priority even when cnt==GAP_CYC-1.
  - btn_n=1 and cnt==GAP_CYC-1 → IDLE, single_click pulse.
  - Otherwise → cnt++.
- WAIT_REL:
  - btn_n=1 → IDLE. No event, regardless of how long the second press lasts.
- HOLD:
  - btn_n=1 → IDLE. No event on release.
- held = 1 exactly while in HOLD.
- busy = 1 in every state except IDLE.
- At most one of single_click, double_click or long_press is high in any cycle. Exactly one event is produced per gesture.
- After single_click, a low sample on the very next edge starts a fresh PRESS1. It is not treated as a double click.
- Reset asserted mid-gesture: every output clears immediately and asynchronously, and the state returns to IDLE. No pending event is emitted after reset releases. If btn_n is low when reset releases, this starts a new PRESS1.

## Timing

- Let edge E0 be the first edge at which btn_n=0 is sampled in IDLE.
  - busy rises in the cycle after E0.
- Long press: long_press is high for the one cycle following the edge E0+(LONG_CYC-1), i.e. after LONG_CYC consecutive low samples.
  - held rises in that same cycle.
- Single click: if the release is sampled at edge R, single_click is high for the one cycle after edge R+(GAP_CYC-1).
  - busy falls in that same cycle.
- Double click: double_click is high for the one cycle after the first low sample in WAIT_GAP.
  - This is at most GAP_CYC-1 edges after R.
- The block adds no latency beyond the one register stage above. There is no back-pressure: pulses are not held and must be consumed in the cycle they appear.

## Test plan

All scenarios use LONG_CYC=20, GAP_CYC=10.

1. Reset check: assert rst_n=0 while btn_n toggles → all outputs 0. After release with btn_n=1 → outputs stay 0 and busy=0.
2. Single click: btn_n low for 5 edges, then high → single_click=1 for exactly one cycle after the 10th high sample. busy falls in the same cycle. No other pulses.
3. Double-click boundary: press 5, high 9, press 5 → double_click=1 one cycle after the first low sample of the second press, no single_click, busy falls after the second release. Repeat with high 10 → single_click after the 10th high sample, then the 11th sample (low) starts a new PRESS1 with no double_click.
4. Long press: btn_n low for 30 edges → long_press=1 one cycle after the 20th low sample. held stays high until the release is sampled. No single_click after the release.
5. Borderline hold: press for 19 edges, then release → no long_press. single_click follows 10 high samples later.
6. Reset mid-operation: assert reset during PRESS1 (cnt=15) and again during WAIT_GAP (cnt=5) → outputs clear and busy=0 immediately, with no event after release. Release reset with btn_n=0 held for 20 edges → long_press fires 20 samples after release.

Source files
------------

// File: rtl/btn_press_decoder.sv
// Classifies debounced active-low button gestures into single-click, double-click
// and long-press events, each reported as a registered one-cycle pulse.
module btn_press_decoder #(
    parameter int LONG_CYC = 50_000_000,
    parameter int GAP_CYC  = 15_000_000,
    parameter int CW       = 26
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_n,
    output logic single_click,
    output logic double_click,
    output logic long_press,
    output logic held,
    output logic busy
);

    typedef enum logic [2:0] {
        IDLE,
        PRESS1,
        WAIT_GAP,
        WAIT_REL,
        HOLD
    } state_t;

    localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYC - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYC - 1);

    state_t        state, next_state;
    logic [CW-1:0] cnt, next_cnt;
    logic          next_single, next_double, next_long;

    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    always_comb begin
        next_state  = state;
        next_cnt    = cnt;
        next_single = 1'b0;
        next_double = 1'b0;
        next_long   = 1'b0;
        case (state)
            IDLE: begin
                if (!btn_n) begin
                    next_state = PRESS1;
                    next_cnt   = CW'(1);
                end
            end
            PRESS1: begin
                if (btn_n) begin
                    next_state = WAIT_GAP;
                    next_cnt   = CW'(1);
                end else if (cnt == LONG_LAST) begin
                    next_state = HOLD;
                    next_long  = 1'b1;
                end else begin
                    next_cnt = cnt + CW'(1);
                end
            end
            WAIT_GAP: begin
                // A new press wins over window expiry on the same sample.
                if (!btn_n) begin
                    next_state  = WAIT_REL;
                    next_double = 1'b1;
                end else if (cnt == GAP_LAST) begin
                    next_state  = IDLE;
                    next_single = 1'b1;
                end else begin
                    next_cnt = cnt + CW'(1);
                end
            end
            WAIT_REL, HOLD: begin
                if (btn_n) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            single_click <= 1'b0;
            double_click <= 1'b0;
            long_press   <= 1'b0;
            held         <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state        <= next_state;
            cnt          <= next_cnt;
            single_click <= next_single;
            double_click <= next_double;
            long_press   <= next_long;
            held         <= (next_state == HOLD);
            busy         <= (next_state != IDLE);
        end
    end

endmodule
